// File: rtl/header_inserter_if.sv
// Avalon-ST style stream bundle shared by the payload input and the framed output
// of header_inserter.
interface header_inserter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic                   valid;
  logic                   sop;
  logic                   eop;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   ready;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_inserter.sv
// Prepends a latched {dest_mac, source_mac} header to each payload packet, emitted as
// whole stream words ahead of a zero-latency payload pass-through.
module header_inserter #(
  parameter int DATA_WIDTH  = 32,
  parameter int HEADER_SIZE = 96,
  parameter int EMPTY_WIDTH = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HEADER_SIZE-1:0] header_data,
  header_inserter_if.slave       data_in,
  header_inserter_if.master      data_out,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int HDR_WORDS = HEADER_SIZE / DATA_WIDTH;
  localparam int IDX_W     = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [HEADER_SIZE-1:0] hdr_q, hdr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0]  hdr_words_s [HDR_WORDS];
  logic                   in_ready_s;
  logic                   out_valid_s;
  logic [DATA_WIDTH-1:0]  out_data_s;
  logic                   out_sop_s;
  logic                   out_eop_s;
  logic [EMPTY_WIDTH-1:0] out_empty_s;

  // Slice the latched header into stream words, most significant (dest MAC) word first.
  always_comb begin
    for (int i = 0; i < HDR_WORDS; i++) begin
      hdr_words_s[i] = hdr_q[HEADER_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH];
    end
  end

  // Next-state, counter updates and stream outputs for the framing FSM.
  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    pkt_cnt_d   = pkt_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = {DATA_WIDTH{1'b0}};
    out_sop_s   = 1'b0;
    out_eop_s   = 1'b0;
    out_empty_s = {EMPTY_WIDTH{1'b0}};

    case (state_q)
      IDLE: begin
        // The sop word is left on the input so it can follow the header as payload.
        in_ready_s = ~data_in.sop;
        if (data_in.valid && data_in.sop) begin
          state_d = HEADER;
          hdr_d   = header_data;
          idx_d   = {IDX_W{1'b0}};
        end else if (data_in.valid) begin
          drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end else begin
          state_d = IDLE;
        end
      end

      HEADER: begin
        out_valid_s = 1'b1;
        out_data_s  = hdr_words_s[idx_q];
        out_sop_s   = (idx_q == {IDX_W{1'b0}});
        if (data_out.ready && (idx_q == LAST_IDX)) begin
          state_d = PAYLOAD;
          idx_d   = {IDX_W{1'b0}};
        end else if (data_out.ready) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          idx_d = idx_q;
        end
      end

      PAYLOAD: begin
        out_valid_s = data_in.valid;
        in_ready_s  = data_out.ready;
        out_data_s  = data_in.data;
        out_eop_s   = data_in.eop;
        out_empty_s = data_in.empty;
        if (data_in.valid && data_out.ready && data_in.eop) begin
          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
          state_d   = IDLE;
        end else begin
          state_d = PAYLOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched header, header word index and status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_q      <= {HEADER_SIZE{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      pkt_cnt_q  <= {CNT_WIDTH{1'b0}};
      drop_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      idx_q      <= idx_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data_in.ready  = in_ready_s;
  assign data_out.valid = out_valid_s;
  assign data_out.data  = out_data_s;
  assign data_out.sop   = out_sop_s;
  assign data_out.eop   = out_eop_s;
  assign data_out.empty = out_empty_s;
  assign pkt_count      = pkt_cnt_q;
  assign drop_count     = drop_cnt_q;

endmodule
